// File: rtl/nf_lsu_pkg.sv
// Shared definitions for the load/store unit: bus size encodings, FSM state
// type and the store-lane replication helper.
package nf_lsu_pkg;

    localparam logic [1:0] LSU_SZ_B = 2'b00;
    localparam logic [1:0] LSU_SZ_H = 2'b01;
    localparam logic [1:0] LSU_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

    // Size 11 is folded onto word so the bus never sees the reserved code.
    function automatic logic [1:0] lsu_norm_size(input logic [1:0] size);
        return (size == 2'b11) ? LSU_SZ_W : size;
    endfunction

    // Replicate the right-aligned store data across all byte lanes.
    function automatic logic [31:0] lsu_replicate(input logic [31:0] wd,
                                                  input logic [1:0]  size);
        logic [31:0] lanes;
        case (size)
            LSU_SZ_B: lanes = {4{wd[7:0]}};
            LSU_SZ_H: lanes = {2{wd[15:0]}};
            default:  lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/nf_lsu_align.sv
// Combinational read-data alignment: picks the addressed byte/half out of the
// bus word and zero- or sign-extends it to 32 bits.
module nf_lsu_align
    import nf_lsu_pkg::*;
(
    input  logic [31:0] rd_dm,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] rd_aligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select and extension.
    always_comb begin
        byte_v     = rd_dm[7:0];
        half_v     = addr[1] ? rd_dm[31:16] : rd_dm[15:0];
        rd_aligned = rd_dm;
        case (addr)
            2'b00:   byte_v = rd_dm[7:0];
            2'b01:   byte_v = rd_dm[15:8];
            2'b10:   byte_v = rd_dm[23:16];
            default: byte_v = rd_dm[31:24];
        endcase
        case (size)
            LSU_SZ_B: rd_aligned = {{24{sign & byte_v[7]}}, byte_v};
            LSU_SZ_H: rd_aligned = {{16{sign & half_v[15]}}, half_v};
            default:  rd_aligned = rd_dm;
        endcase
    end

endmodule

// File: rtl/nf_lsu.sv
// Load/store unit: latches a memory-stage access, runs one bus handshake and
// returns a single-cycle completion pulse to release the pipeline stall.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   LSU_IDLE | waiting for a load or store from the memory stage
//   LSU_REQ  | bus request held with stable outputs until ack_dm
//   LSU_DONE | one-cycle req_ack_dm pulse, then back to idle
module nf_lsu
    import nf_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_dm_imem,
    input  logic [31:0] wd_dm_imem,
    input  logic        we_dm_imem,
    input  logic        rf_src_imem,
    input  logic [1:0]  size_dm_imem,
    input  logic        sign_dm_imem,
    output logic        req_ack_dm,
    output logic [31:0] rd_dm_iwb,
    output logic [31:0] addr_dm,
    output logic [31:0] wd_dm,
    output logic        we_dm,
    output logic [1:0]  size_dm,
    output logic        req_dm,
    input  logic        ack_dm,
    input  logic [31:0] rd_dm
);

    lsu_state_t  state, state_next;
    logic        sign_q;
    logic        load_q;
    logic        start;
    logic        finish;
    logic [31:0] rd_aligned;

    nf_lsu_align u_align (
        .rd_dm      (rd_dm),
        .addr       (addr_dm[1:0]),
        .size       (size_dm),
        .sign       (sign_q),
        .rd_aligned (rd_aligned)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs; ack_dm only matters in LSU_REQ.
    always_comb begin
        state_next = state;
        req_dm     = 1'b0;
        req_ack_dm = 1'b0;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (we_dm_imem | rf_src_imem) begin
                    start      = 1'b1;
                    state_next = LSU_REQ;
                end
            end
            LSU_REQ: begin
                req_dm = 1'b1;
                if (ack_dm) begin
                    finish     = 1'b1;
                    state_next = LSU_DONE;
                end
            end
            LSU_DONE: begin
                req_ack_dm = 1'b1;
                state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
    end

    // Access capture; a simultaneous load+store is performed as a store only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_dm <= '0;
            wd_dm   <= '0;
            we_dm   <= 1'b0;
            size_dm <= LSU_SZ_B;
            sign_q  <= 1'b0;
            load_q  <= 1'b0;
        end else if (start) begin
            addr_dm <= addr_dm_imem;
            wd_dm   <= lsu_replicate(wd_dm_imem, lsu_norm_size(size_dm_imem));
            we_dm   <= we_dm_imem;
            size_dm <= lsu_norm_size(size_dm_imem);
            sign_q  <= sign_dm_imem;
            load_q  <= rf_src_imem & ~we_dm_imem;
        end
    end

    // Load result; held across stores and idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rd_dm_iwb <= '0;
        else if (finish & load_q) rd_dm_iwb <= rd_aligned;
    end

endmodule

// File: tb/tb_nf_lsu.sv
// Self-checking bench for nf_lsu: directed scenarios plus randomized accesses
// compared against a behavioural model of the load/store rules.
module tb_nf_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_dm_imem, wd_dm_imem;
    logic        we_dm_imem, rf_src_imem, sign_dm_imem;
    logic [1:0]  size_dm_imem;
    logic        req_ack_dm;
    logic [31:0] rd_dm_iwb, addr_dm, wd_dm;
    logic        we_dm;
    logic [1:0]  size_dm;
    logic        req_dm;
    logic        ack_dm;
    logic [31:0] rd_dm;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_pulse_cyc = 0;
    logic [31:0] exp_rd = 32'h0;

    nf_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .addr_dm_imem (addr_dm_imem),
        .wd_dm_imem   (wd_dm_imem),
        .we_dm_imem   (we_dm_imem),
        .rf_src_imem  (rf_src_imem),
        .size_dm_imem (size_dm_imem),
        .sign_dm_imem (sign_dm_imem),
        .req_ack_dm   (req_ack_dm),
        .rd_dm_iwb    (rd_dm_iwb),
        .addr_dm      (addr_dm),
        .wd_dm        (wd_dm),
        .we_dm        (we_dm),
        .size_dm      (size_dm),
        .req_dm       (req_dm),
        .ack_dm       (ack_dm),
        .rd_dm        (rd_dm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: what the write-back stage should see for a load.
    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        int w;
        if (sz == 2'd0) begin
            v = (d >> (8 * a[1:0])) & 32'hFF;
            w = 8;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * a[1])) & 32'hFFFF;
            w = 16;
        end else begin
            return d;
        end
        if (sg && v[w-1]) v = v | (32'hFFFF_FFFF << w);
        return v;
    endfunction

    // Reference: store data as it should appear on the bus.
    function automatic logic [31:0] model_store(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic scramble_inputs();
        addr_dm_imem = $urandom;
        wd_dm_imem   = $urandom;
        size_dm_imem = 2'($urandom_range(0, 3));
        sign_dm_imem = 1'($urandom_range(0, 1));
        we_dm_imem   = 1'($urandom_range(0, 1));
        rf_src_imem  = 1'($urandom_range(0, 1));
    endtask

    // Entered at a negedge of an IDLE cycle; returns at a negedge of the IDLE
    // cycle after DONE, so calls chain back-to-back.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic ld, input logic [1:0] sz, input logic sg,
                          input int wait_n, input logic [31:0] rdata, input logic hold_ack);
        logic [1:0]  exp_sz;
        logic [31:0] exp_wd;
        int c, n_req;
        bit got;
        exp_sz = (sz == 2'd3) ? 2'd2 : sz;
        exp_wd = model_store(wd, exp_sz);
        addr_dm_imem = a; wd_dm_imem = wd; we_dm_imem = we; rf_src_imem = ld;
        size_dm_imem = sz; sign_dm_imem = sg;
        if (wait_n > 0) ack_dm = 1'b0;
        rd_dm = $urandom;
        @(negedge clk);
        c = 2; n_req = 0; got = 0;
        while (c <= wait_n + 10) begin
            if (req_dm) begin
                n_req++;
                check("addr_dm", addr_dm, a);
                check("wd_dm", wd_dm, exp_wd);
                check("we_dm", 32'(we_dm), 32'(we));
                check("size_dm", 32'(size_dm), 32'(exp_sz));
            end
            if (req_ack_dm) begin got = 1; break; end
            ack_dm = (n_req >= wait_n + 1);
            rd_dm  = ack_dm ? rdata : $urandom;
            scramble_inputs();
            @(negedge clk);
            c++;
        end
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            last_pulse_cyc = cyc;
            check("latency", c, 3 + wait_n);
            check("req_cycles", n_req, wait_n + 1);
            if (ld && !we) exp_rd = model_load(rdata, a, exp_sz, sg);
            check("rd_dm_iwb", rd_dm_iwb, exp_rd);
        end
        if (!hold_ack) ack_dm = 1'b0;
        rd_dm = $urandom;
        scramble_inputs();
        @(negedge clk);
        check("pulse_width", 32'(req_ack_dm), 32'd0);
        check("idle_req", 32'(req_dm), 32'd0);
        we_dm_imem = 1'b0; rf_src_imem = 1'b0;
    endtask

    initial begin
        int p1;
        rst = 1'b1; ack_dm = 1'b0; rd_dm = '0;
        addr_dm_imem = '0; wd_dm_imem = '0; we_dm_imem = 1'b0; rf_src_imem = 1'b0;
        size_dm_imem = '0; sign_dm_imem = 1'b0;
        #12;
        check("rst_req_dm", 32'(req_dm), 32'd0);
        check("rst_req_ack", 32'(req_ack_dm), 32'd0);
        check("rst_addr", addr_dm, 32'h0);
        check("rst_wd", wd_dm, 32'h0);
        check("rst_we_size", {29'd0, we_dm, size_dm}, 32'd0);
        check("rst_rd_iwb", rd_dm_iwb, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Word load, ack in first REQ cycle.
        access(32'h100, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        check("word_load", rd_dm_iwb, 32'hDEADBEEF);
        // Byte load at lane 3, signed then unsigned.
        access(32'h103, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1, 0, 32'h80112233, 1'b0);
        check("byte_signed", rd_dm_iwb, 32'hFFFFFF80);
        access(32'h103, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 0, 32'h80112233, 1'b0);
        check("byte_unsigned", rd_dm_iwb, 32'h00000080);
        // Half store with four wait cycles; load result must not move.
        access(32'h202, 32'h0000ABCD, 1'b1, 1'b0, 2'd1, 1'b0, 4, 32'h12345678, 1'b0);
        check("store_keeps_rd", rd_dm_iwb, 32'h00000080);
        // Store and load together behaves as a store.
        access(32'h204, 32'h11223344, 1'b1, 1'b1, 2'd2, 1'b0, 1, 32'hCAFEF00D, 1'b0);
        check("both_is_store", rd_dm_iwb, 32'h00000080);
        // Two back-to-back loads with ack held high throughout.
        ack_dm = 1'b1;
        access(32'h300, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1, 0, 32'h8000_7FFF, 1'b1);
        p1 = last_pulse_cyc;
        check("half_lo", rd_dm_iwb, 32'h00007FFF);
        access(32'h302, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1, 0, 32'h8000_7FFF, 1'b1);
        check("half_hi", rd_dm_iwb, 32'hFFFF8000);
        check("b2b_spacing", last_pulse_cyc - p1, 3);
        // Ack held high in idle must not start or complete anything.
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_ignored", {30'd0, req_ack_dm, req_dm}, 32'd0);
        end
        ack_dm = 1'b0;

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            access($urandom, $urandom, kind != 0, kind != 1, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom,
                   1'($urandom_range(0, 1)));
        end
        ack_dm = 1'b0;

        // Reset in the middle of a request abandons it.
        addr_dm_imem = 32'h400; we_dm_imem = 1'b0; rf_src_imem = 1'b1; size_dm_imem = 2'd2;
        @(negedge clk);
        we_dm_imem = 1'b0; rf_src_imem = 1'b0;
        check("pre_rst_req", 32'(req_dm), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_req", 32'(req_dm), 32'd0);
        check("rst_async_addr", addr_dm, 32'h0);
        check("rst_async_rd", rd_dm_iwb, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ack_dm = 1'b1; rd_dm = 32'h5555AAAA;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_quiet", {30'd0, req_ack_dm, req_dm}, 32'd0);
        end
        check("post_rst_rd", rd_dm_iwb, 32'h0);
        ack_dm = 1'b0;
        exp_rd = 32'h0;
        access(32'h1, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1, 2, 32'h0000_7F00, 1'b0);
        check("post_rst_load", rd_dm_iwb, 32'h0000007F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nf_lsu.md
NF_LSU -- requirements
Module: nf_lsu

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-016, named exactly as listed: one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 addr_dm_imem  in  32  byte address of the memory-stage access.
REQ-005 wd_dm_imem  in  32  store data; valid bits are right-aligned.
REQ-006 we_dm_imem  in  1  memory-stage instruction is a store.
REQ-007 rf_src_imem  in  1  memory-stage instruction is a load.
REQ-008 size_dm_imem  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 sign_dm_imem  in  1  load is sign-extended when 1 and zero-extended when 0.
REQ-010 req_ack_dm  out  1  one-cycle completion pulse to the hazard unit; releases the pipeline stall.
REQ-011 rd_dm_iwb  out  32  aligned and extended load result for the write-back stage.
REQ-012 addr_dm  out  32  bus address, equal to the registered addr_dm_imem.
REQ-013 wd_dm  out  32  bus write data with the byte lanes replicated.
REQ-014 we_dm / size_dm  out  1 / 2  bus write enable and bus access size.
REQ-015 req_dm  out  1  bus request; it stays high until ack_dm is seen.
REQ-016 ack_dm in 1; rd_dm in 32: bus acknowledge, and bus read data that is valid while ack_dm=1.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-018 IDLE -> REQ: when (we_dm_imem | rf_src_imem)=1, register addr, data, we, size and sign at the same edge; otherwise stay in IDLE.
REQ-019 In REQ, req_dm=1 and the bus outputs SHALL be held stable. REQ -> DONE occurs on the first cycle with ack_dm=1; for a load, the aligned rd_dm is captured into rd_dm_iwb at that edge.
REQ-020 In DONE, req_ack_dm=1 for exactly one cycle; DONE -> IDLE is unconditional.
REQ-021 Minimum latency is 3 cycles from detection in IDLE to the req_ack_dm pulse, when ack_dm arrives in the first REQ cycle. Each additional ack_dm wait cycle adds 1.
REQ-022 Back-to-back accesses: the next access SHALL be detectable in the IDLE cycle that follows DONE, with no extra bubble.
REQ-023 If we_dm_imem and rf_src_imem are both 1, the access SHALL be performed as a store and no load capture occurs.
REQ-024 Store lane replication: byte gives {4{wd[7:0]}}, half gives {2{wd[15:0]}}, word gives wd.
REQ-025 Load extraction for a byte SHALL use lane addr[1:0].
REQ-026 Load extraction for a half SHALL use the half at addr[1]; addr[0] is ignored.
REQ-027 Load extraction for a word SHALL ignore addr[1:0].
REQ-028 Loaded values SHALL be zero- or sign-extended from bit 7 or bit 15 according to the registered sign flag.
REQ-029 An ack_dm received in IDLE or DONE SHALL be ignored.
REQ-030 An ack_dm that stays high for several cycles SHALL complete only one access.
REQ-031 rd_dm_iwb SHALL hold its value until the next load completes; stores SHALL leave it unchanged.

Reset
REQ-032 Asserting rst SHALL immediately force all of the following: state=IDLE, req_dm=0, req_ack_dm=0, we_dm=0, size_dm=00, addr_dm=0, wd_dm=0, rd_dm_iwb=0.
REQ-033 If rst is asserted during REQ, the access SHALL be abandoned with no retry; after release the block starts in IDLE.

Structure
REQ-034 The shared include SHALL define the size encodings (LSU_SZ_B, LSU_SZ_H, LSU_SZ_W) and the FSM state type (LSU_IDLE, LSU_REQ, LSU_DONE).
REQ-035 Read alignment and extension SHALL be a combinational sub-module, nf_lsu_align, with inputs rd_dm, addr[1:0], size and sign.

Verification
REQ-036 Word load at 0x100 with ack_dm in the first REQ cycle and rd_dm=0xDEADBEEF -> rd_dm_iwb=0xDEADBEEF and req_ack_dm pulses in cycle 3, for exactly 1 cycle.
REQ-037 Signed byte load at 0x103 with rd_dm=0x80112233 -> 0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-038 Half store at 0x202 with wd=0x0000ABCD and ack delayed 4 cycles -> wd_dm=0xABCDABCD, size_dm=01 and req_dm high for 5 cycles; rd_dm_iwb unchanged.
REQ-039 Two consecutive loads with ack held high continuously -> exactly two req_ack_dm pulses, spaced 3 cycles apart.
REQ-040 rst asserted in REQ -> req_dm=0 in the same cycle; after release, state=IDLE, and an ack_dm arriving later produces no req_ack_dm.
